histogram_bins: RTL and testbench
=================================

Name: histogram_bins

Overview:
Parametrised histogram accumulator, successor to the free-running 8-bit counter: generalised from one counter to NUM_BINS counters of COUNT_W bits. Each accepted input sample increments the bin selected by its upper bits. Contents are read back through a registered read port. A sweeping clear state machine zeroes all bins.

Parameters:
NUM_BINS, 8, number of bins; power of two, >= 2; BIN_W = clog2(NUM_BINS)
COUNT_W, 8, width of each bin counter
SAMPLE_W, 8, width of input sample; must be >= BIN_W
SATURATE, 1, 1 = bins saturate at max; 0 = bins wrap to 0
TOTAL_W, 16, width of total accepted-sample counter

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
in_valid  in  1  sample present
in_sample  in  SAMPLE_W  sample; bin = in_sample[SAMPLE_W-1 -: BIN_W]
in_ready  out  1  block can accept a sample this cycle
clear_req  in  1  single-cycle pulse; start clear sweep
busy  out  1  clear sweep in progress
rd_en  in  1  read request
rd_bin  in  BIN_W  bin to read
rd_valid  out  1  read data valid
rd_count  out  COUNT_W  read data
total_count  out  TOTAL_W  accepted samples since last clear, saturating
overflow  out  1  sticky; some bin hit max (SATURATE=1) or wrapped (SATURATE=0)
peak_bin  out  BIN_W  bin index holding the highest count (optional feature)
peak_count  out  COUNT_W  highest bin count (optional feature)

Behaviour:
- Reset (async): all bins 0, FSM=IDLE, in_ready=1, busy=0, rd_valid=0, rd_count=0, total_count=0, overflow=0, peak_bin=0, peak_count=0.
- FSM states: IDLE, CLEAR.
- IDLE: in_ready=1; accept on in_valid. Accepted sample increments its bin at the next edge (1-cycle latency). total_count increments and saturates at all-ones.
- clear_req in IDLE -> CLEAR at the next edge. A sample accepted in the same cycle is still counted. Its bin is then zeroed by the sweep.
- CLEAR: in_ready=0, busy=1. Sweep pointer starts at 0 and zeroes one bin per cycle in ascending order. The state lasts exactly NUM_BINS cycles, then returns to IDLE.
- On entering CLEAR: total_count, overflow and peak registers zero.
- clear_req while in CLEAR: ignored; the sweep does not restart.
- in_valid while in_ready=0: the sample is dropped; the source must hold it until in_ready=1.
- Bin at max (all-ones):
  - SATURATE=1: holds its value, overflow<=1.
  - SATURATE=0: wraps to 0, overflow<=1.
- overflow stays set until reset or the next clear.
- Read: rd_en sampled at an edge. rd_valid=1 and rd_count=bin value on the following cycle (1-cycle latency).
- Read and increment of the same bin in the same cycle: returns the pre-increment value.
- Read during CLEAR is allowed. It returns current contents; already-swept bins read 0.
- rd_valid=0 in cycles after rd_en=0; rd_count holds its last value.
- Reset asserted mid-sweep or mid-read: immediate return to the reset state. No partial state survives.

Optional Feature:
- Macro HIST_PEAK_EN.
- Defined:
  - On each increment of bin b to new value v, if v > peak_count then peak_bin<=b and peak_count<=v in the same edge as the bin update.
  - Ties keep the earlier peak.
  - A wrap (SATURATE=0) never lowers the peak.
  - Peak registers are zeroed on clear.
- Not defined: peak_bin and peak_count are tied to 0; no peak logic is synthesised.

Test Plan:
Reset then samples 0x00,0x20,0x20,0xE0 (NUM_BINS=8, SAMPLE_W=8) -> reads give bin0=1, bin1=2, bin7=1, others 0; total_count=4; overflow=0.
COUNT_W=4, SATURATE=1, 17 samples to bin 3 -> bin3=15, overflow=1, total_count=17; with SATURATE=0 -> bin3=1, overflow=1.
clear_req with in_valid sample same cycle -> sample counted, then busy=1 and in_ready=0 for exactly 8 cycles; all bins 0, total_count=0, overflow=0 afterwards.
rd_en on bin 5 in same cycle as increment of bin 5 (value 6) -> next cycle rd_valid=1, rd_count=6; subsequent read returns 7.
Assert rst during cycle 3 of the clear sweep -> all outputs at reset values immediately; in_ready=1 after release; a second clear_req mid-sweep does not extend the sweep.
HIST_PEAK_EN: samples to bin 2 twice, then bin 6 twice, then bin 6 once -> peak_bin=2/count=2 after tie, then peak_bin=6/count=3.

Source files
------------

// File: rtl/histogram_bins.sv
// -----------------------------------------------------------------------------
// histogram_bins
//
// Histogram accumulator: NUM_BINS counters of COUNT_W bits. Each accepted
// sample increments the bin addressed by its top BIN_W bits. Bins are read
// back through a registered read port. A clear state machine sweeps through
// the bins, zeroing one per cycle.
//
// Optional feature: define HIST_PEAK_EN to track the bin with the highest
// count (peak_bin / peak_count). When undefined, both outputs are tied to 0.
//
// Ports:
//   clk         rising-edge clock for all state
//   rst         asynchronous, active-high reset
//   in_valid    a sample is present on in_sample
//   in_sample   sample; bin = in_sample[SAMPLE_W-1 -: BIN_W]
//   in_ready    a sample can be accepted this cycle (high in IDLE)
//   clear_req   single-cycle pulse that starts a clear sweep
//   busy        clear sweep in progress
//   rd_en       read request, sampled at the clock edge
//   rd_bin      bin to read
//   rd_valid    read data valid (one cycle after rd_en)
//   rd_count    read data; holds its last value when no read is made
//   total_count accepted samples since the last clear, saturating
//   overflow    sticky: some bin reached max (SATURATE=1) or wrapped (=0)
//   peak_bin    index of the bin with the highest count
//   peak_count  highest bin count
// -----------------------------------------------------------------------------
module histogram_bins #(
    parameter int NUM_BINS  = 8,
    parameter int COUNT_W   = 8,
    parameter int SAMPLE_W  = 8,
    parameter int SATURATE  = 1,
    parameter int TOTAL_W   = 16,
    localparam int BIN_W    = $clog2(NUM_BINS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    input  logic [SAMPLE_W-1:0] in_sample,
    output logic                in_ready,
    input  logic                clear_req,
    output logic                busy,
    input  logic                rd_en,
    input  logic [BIN_W-1:0]    rd_bin,
    output logic                rd_valid,
    output logic [COUNT_W-1:0]  rd_count,
    output logic [TOTAL_W-1:0]  total_count,
    output logic                overflow,
    output logic [BIN_W-1:0]    peak_bin,
    output logic [COUNT_W-1:0]  peak_count
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     sweep_q, sweep_d;
    logic [COUNT_W-1:0]   bins_q [NUM_BINS];
    logic [COUNT_W-1:0]   bins_d [NUM_BINS];
    logic                 rd_valid_q, rd_valid_d;
    logic [COUNT_W-1:0]   rd_count_q, rd_count_d;
    logic [TOTAL_W-1:0]   total_q, total_d;
    logic                 overflow_q, overflow_d;

    logic                 accept;
    logic [BIN_W-1:0]     sample_bin;
    logic [COUNT_W-1:0]   cur_val;
    logic [COUNT_W-1:0]   new_val;
    logic                 at_max;

    // Only the top BIN_W bits select a bin; the remaining sample bits are
    // intentionally ignored.
    logic                 unused_sample_bits;
    assign unused_sample_bits = ^in_sample;

`ifdef HIST_PEAK_EN
    logic [BIN_W-1:0]     peak_bin_q, peak_bin_d;
    logic [COUNT_W-1:0]   peak_count_q, peak_count_d;
`endif

    assign in_ready   = (state_q == ST_IDLE);
    assign busy       = (state_q == ST_CLEAR);
    assign accept     = in_valid && in_ready;
    assign sample_bin = in_sample[SAMPLE_W-1 -: BIN_W];
    assign cur_val    = bins_q[sample_bin];
    assign at_max     = &cur_val;

    // At max the bin either holds (saturating) or rolls over to zero.
    assign new_val = !at_max       ? cur_val + COUNT_W'(1) :
                     (SATURATE != 0) ? cur_val : '0;

    // NOTE: every signal assigned here gets a default first, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        bins_d     = bins_q;
        total_d    = total_q;
        overflow_d = overflow_q;
        rd_valid_d = rd_en;
        // Reads see the pre-edge contents, so a read racing an increment of
        // the same bin returns the old value.
        rd_count_d = rd_en ? bins_q[rd_bin] : rd_count_q;
`ifdef HIST_PEAK_EN
        peak_bin_d   = peak_bin_q;
        peak_count_d = peak_count_q;
`endif

        if (accept) begin
            bins_d[sample_bin] = new_val;
            if (at_max) begin
                overflow_d = 1'b1;
            end
            if (!(&total_q)) begin
                total_d = total_q + TOTAL_W'(1);
            end
`ifdef HIST_PEAK_EN
            // Strictly greater: ties keep the earlier peak, and a wrap to 0
            // can never lower it.
            if (new_val > peak_count_q) begin
                peak_bin_d   = sample_bin;
                peak_count_d = new_val;
            end
`endif
        end

        unique case (state_q)
            ST_IDLE: begin
                if (clear_req) begin
                    // A sample accepted this cycle still lands in its bin;
                    // the sweep zeroes it afterwards. The summary registers
                    // are zeroed on entry, overriding this cycle's update.
                    state_d    = ST_CLEAR;
                    sweep_d    = '0;
                    total_d    = '0;
                    overflow_d = 1'b0;
`ifdef HIST_PEAK_EN
                    peak_bin_d   = '0;
                    peak_count_d = '0;
`endif
                end
            end
            ST_CLEAR: begin
                // clear_req is ignored here; the sweep never restarts.
                bins_d[sweep_q] = '0;
                sweep_d         = sweep_q + BIN_W'(1);
                if (sweep_q == BIN_W'(NUM_BINS - 1)) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: the bin array is built from flops rather than RAM because the
    // bins must read as zero straight out of reset; a RAM cannot be reset.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            sweep_q    <= '0;
            bins_q     <= '{default: '0};
            rd_valid_q <= 1'b0;
            rd_count_q <= '0;
            total_q    <= '0;
            overflow_q <= 1'b0;
`ifdef HIST_PEAK_EN
            peak_bin_q   <= '0;
            peak_count_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            bins_q     <= bins_d;
            rd_valid_q <= rd_valid_d;
            rd_count_q <= rd_count_d;
            total_q    <= total_d;
            overflow_q <= overflow_d;
`ifdef HIST_PEAK_EN
            peak_bin_q   <= peak_bin_d;
            peak_count_q <= peak_count_d;
`endif
        end
    end

    assign rd_valid    = rd_valid_q;
    assign rd_count    = rd_count_q;
    assign total_count = total_q;
    assign overflow    = overflow_q;

`ifdef HIST_PEAK_EN
    assign peak_bin   = peak_bin_q;
    assign peak_count = peak_count_q;
`else
    assign peak_bin   = '0;
    assign peak_count = '0;
`endif

endmodule

// File: tb/tb_histogram_bins.sv
// -----------------------------------------------------------------------------
// tb_histogram_bins
//
// Directed bench for histogram_bins. Three instances share one stimulus:
// the default configuration, and COUNT_W=4 builds with SATURATE=1 and
// SATURATE=0 for the bin-at-max behaviour. Outputs are sampled on the
// falling edge; inputs change on the falling edge.
// -----------------------------------------------------------------------------
module tb_histogram_bins;

`ifdef HIST_PEAK_EN
    localparam bit PEAK_EN = 1'b1;
`else
    localparam bit PEAK_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_sample;
    logic       clear_req;
    logic       rd_en;
    logic [2:0] rd_bin;

    // default instance
    logic        m_in_ready, m_busy, m_rd_valid, m_overflow;
    logic [7:0]  m_rd_count, m_peak_count;
    logic [15:0] m_total;
    logic [2:0]  m_peak_bin;
    // COUNT_W=4 saturating instance
    logic        s_in_ready, s_busy, s_rd_valid, s_overflow;
    logic [3:0]  s_rd_count, s_peak_count;
    logic [15:0] s_total;
    logic [2:0]  s_peak_bin;
    // COUNT_W=4 wrapping instance
    logic        w_in_ready, w_busy, w_rd_valid, w_overflow;
    logic [3:0]  w_rd_count, w_peak_count;
    logic [15:0] w_total;
    logic [2:0]  w_peak_bin;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    histogram_bins u_main (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
        .in_ready(m_in_ready), .clear_req(clear_req), .busy(m_busy),
        .rd_en(rd_en), .rd_bin(rd_bin), .rd_valid(m_rd_valid),
        .rd_count(m_rd_count), .total_count(m_total), .overflow(m_overflow),
        .peak_bin(m_peak_bin), .peak_count(m_peak_count)
    );

    histogram_bins #(.COUNT_W(4), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
        .in_ready(s_in_ready), .clear_req(clear_req), .busy(s_busy),
        .rd_en(rd_en), .rd_bin(rd_bin), .rd_valid(s_rd_valid),
        .rd_count(s_rd_count), .total_count(s_total), .overflow(s_overflow),
        .peak_bin(s_peak_bin), .peak_count(s_peak_count)
    );

    histogram_bins #(.COUNT_W(4), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_sample(in_sample),
        .in_ready(w_in_ready), .clear_req(clear_req), .busy(w_busy),
        .rd_en(rd_en), .rd_bin(rd_bin), .rd_valid(w_rd_valid),
        .rd_count(w_rd_count), .total_count(w_total), .overflow(w_overflow),
        .peak_bin(w_peak_bin), .peak_count(w_peak_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // one accepted sample per call
    task automatic push(input logic [7:0] s);
        in_valid  = 1'b1;
        in_sample = s;
        step();
        in_valid  = 1'b0;
    endtask

    // registered read of one bin; leaves rd_en low afterwards
    task automatic read_bin(input logic [2:0] b);
        rd_en  = 1'b1;
        rd_bin = b;
        step();
        rd_en  = 1'b0;
    endtask

    int exp_bins [8];
    int busy_cycles;

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_sample = '0;
        clear_req = 1'b0;
        rd_en     = 1'b0;
        rd_bin    = '0;

        // ---------------- reset state ----------------
        @(negedge clk);
        check("rst_in_ready",  m_in_ready,  1);
        check("rst_busy",      m_busy,      0);
        check("rst_rd_valid",  m_rd_valid,  0);
        check("rst_rd_count",  m_rd_count,  0);
        check("rst_total",     m_total,     0);
        check("rst_overflow",  m_overflow,  0);
        check("rst_peak_bin",  m_peak_bin,  0);
        check("rst_peak_cnt",  m_peak_count, 0);
        rst = 1'b0;
        step();

        // ---------------- basic accumulation ----------------
        push(8'h00);
        push(8'h20);
        push(8'h20);
        push(8'hE0);
        exp_bins = '{1, 2, 0, 0, 0, 0, 0, 1};
        for (int i = 0; i < 8; i++) begin
            read_bin(3'(i));
            check($sformatf("basic_rd_valid_%0d", i), m_rd_valid, 1);
            check($sformatf("basic_bin_%0d", i), m_rd_count, exp_bins[i]);
        end
        check("basic_total",    m_total,    4);
        check("basic_overflow", m_overflow, 0);
        // no read this cycle: rd_valid drops, rd_count holds bin7's value
        step();
        check("idle_rd_valid", m_rd_valid, 0);
        check("idle_rd_hold",  m_rd_count, 1);

        // ---------------- read racing increment ----------------
        for (int i = 0; i < 6; i++) push(8'hA0);
        in_valid  = 1'b1;
        in_sample = 8'hA0;
        rd_en     = 1'b1;
        rd_bin    = 3'd5;
        step();
        in_valid  = 1'b0;
        rd_en     = 1'b0;
        check("race_rd_valid", m_rd_valid, 1);
        check("race_pre_inc",  m_rd_count, 6);
        read_bin(3'd5);
        check("race_post_inc", m_rd_count, 7);
        check("race_total",    m_total,    11);

        // ---------------- clear with coincident sample ----------------
        check("pre_clr_ready", m_in_ready, 1);
        clear_req = 1'b1;
        in_valid  = 1'b1;
        in_sample = 8'h40;              // bin 2, currently 0
        step();
        // sweep in progress; a bin-7 sample is held on the input the whole time
        in_sample   = 8'hE0;
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!m_busy) break;
            busy_cycles++;
            check($sformatf("clr_in_ready_%0d", i), m_in_ready, 0);
            if (i == 0) begin
                check("clr_total_zero", m_total,    0);
                check("clr_ovf_zero",   m_overflow, 0);
            end
            if (i == 1) check("clr_sample_counted", m_rd_count, 1);
            clear_req = (i == 3);       // mid-sweep request must be ignored
            rd_en     = (i == 0);
            rd_bin    = 3'd2;
            step();
        end
        in_valid  = 1'b0;
        clear_req = 1'b0;
        rd_en     = 1'b0;
        check("clr_busy_cycles", busy_cycles, 8);
        check("clr_ready_after", m_in_ready,  1);
        for (int i = 0; i < 8; i++) begin
            read_bin(3'(i));
            check($sformatf("clr_bin_%0d", i), m_rd_count, 0);
        end
        check("clr_total_after", m_total,    0);
        check("clr_ovf_after",   m_overflow, 0);

        // ---------------- bin at max (COUNT_W=4 instances) ----------------
        for (int i = 0; i < 17; i++) push(8'h60);   // bin 3
        push(8'h00);
        push(8'h00);                                 // bin 0 = 2
        read_bin(3'd3);
        check("max_main_bin3", m_rd_count, 17);
        check("max_sat_bin3",  s_rd_count, 15);
        check("max_wrap_bin3", w_rd_count, 1);
        check("max_main_ovf",  m_overflow, 0);
        check("max_sat_ovf",   s_overflow, 1);
        check("max_wrap_ovf",  w_overflow, 1);
        check("max_sat_total", s_total,    19);
        check("max_wrap_total", w_total,   19);

        // ---------------- reset in the middle of a sweep ----------------
        clear_req = 1'b1;
        step();                         // sweep cycle 1
        clear_req = 1'b0;
        check("sweep_sat_ovf_cleared", s_overflow, 0);
        rd_en  = 1'b1;
        rd_bin = 3'd3;
        step();                         // sweep cycle 2
        check("sweep_rd_valid",  m_rd_valid, 1);
        check("sweep_rd_unswept", m_rd_count, 17);
        rd_bin    = 3'd0;
        clear_req = 1'b1;
        step();                         // sweep cycle 3
        clear_req = 1'b0;
        rd_en     = 1'b0;
        check("sweep_rd_swept", m_rd_count, 0);
        check("sweep_busy",     m_busy,     1);
        #1 rst = 1'b1;
        #1;
        check("async_busy",     m_busy,     0);
        check("async_in_ready", m_in_ready, 1);
        check("async_rd_valid", m_rd_valid, 0);
        check("async_total",    m_total,    0);
        @(negedge clk);
        rst = 1'b0;
        step();
        check("post_rst_busy",  m_busy,     0);
        check("post_rst_ready", m_in_ready, 1);
        read_bin(3'd3);
        check("post_rst_bin3",  m_rd_count, 0);

        // ---------------- peak tracking ----------------
        push(8'h40);
        push(8'h40);                    // bin 2 = 2
        check("peak_a_bin", m_peak_bin,   PEAK_EN ? 2 : 0);
        check("peak_a_cnt", m_peak_count, PEAK_EN ? 2 : 0);
        push(8'hC0);
        push(8'hC0);                    // bin 6 = 2, tie keeps bin 2
        check("peak_tie_bin", m_peak_bin,   PEAK_EN ? 2 : 0);
        check("peak_tie_cnt", m_peak_count, PEAK_EN ? 2 : 0);
        push(8'hC0);                    // bin 6 = 3
        check("peak_b_bin", m_peak_bin,   PEAK_EN ? 6 : 0);
        check("peak_b_cnt", m_peak_count, PEAK_EN ? 3 : 0);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        check("peak_clr_bin", m_peak_bin,   0);
        check("peak_clr_cnt", m_peak_count, 0);
        busy_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (!m_busy) break;
            busy_cycles++;
            step();
        end
        check("peak_sweep_cycles", busy_cycles, 8);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
